// File: rtl/hamming_code_encoder_tx.sv
// Hamming(7,4) transmit encoder: splits each accepted 8-bit sample into two
// registered codewords (low nibble first). Optional macro: HAMMING_ERR_INJECT_EN.
module hamming_code_encoder_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        parity_type,
    output logic [7:1]  code_out,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        code_last,
    output logic [15:0] cw_count,
    input  logic [2:0]  inj_pos
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  data_hi_q, data_hi_d;
    logic        pt_q, pt_d;
    logic [7:1]  code_q, code_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  lo_pos, hi_pos;

    logic accept;
    logic xfer;

    function automatic logic [7:1] encode(input logic [3:0] nib, input logic pt);
        logic [7:1] cw;
        cw    = '0;
        cw[3] = nib[0];
        cw[5] = nib[1];
        cw[6] = nib[2];
        cw[7] = nib[3];
        cw[1] = cw[3] ^ cw[5] ^ cw[7] ^ pt;
        cw[2] = cw[3] ^ cw[6] ^ cw[7] ^ pt;
        cw[4] = cw[5] ^ cw[6] ^ cw[7] ^ pt;
        return cw;
    endfunction

    // Position 0 means "no injection"; positions 1..7 flip that codeword bit.
    function automatic logic [7:1] flip_bit(input logic [7:1] cw, input logic [2:0] pos);
        logic [7:1] res;
        res = cw;
        for (int i = 1; i <= 7; i++) begin
            if (pos == 3'(i)) res[i] = ~cw[i];
        end
        return res;
    endfunction

`ifdef HAMMING_ERR_INJECT_EN
    logic [2:0] inj_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_q <= '0;
        end else if (accept) begin
            inj_q <= inj_pos;
        end
    end

    assign lo_pos = inj_pos;
    assign hi_pos = inj_q;
`else
    logic unused_inj;
    assign unused_inj = ^inj_pos;
    assign lo_pos     = 3'd0;
    assign hi_pos     = 3'd0;
`endif

    assign s_ready = (state_q == IDLE);
    assign m_valid = (state_q != IDLE);
    assign accept  = s_valid && s_ready;
    assign xfer    = m_valid && m_ready;

    // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)  state_d = SEND_LO;
            SEND_LO: if (m_ready) state_d = SEND_HI;
            SEND_HI: if (m_ready) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // The low codeword is encoded straight from the accepted inputs so it is
    // registered and visible one cycle after accept; only the high nibble is kept.
    always_comb begin
        data_hi_d = data_hi_q;
        pt_d      = pt_q;
        code_d    = code_q;
        last_d    = last_q;
        if (accept) begin
            data_hi_d = s_data[7:4];
            pt_d      = parity_type;
            code_d    = flip_bit(encode(s_data[3:0], parity_type), lo_pos);
            last_d    = 1'b0;
        end else if (state_q == SEND_LO && m_ready) begin
            code_d    = flip_bit(encode(data_hi_q, pt_q), hi_pos);
            last_d    = 1'b1;
        end
    end

    assign cnt_d = cnt_q + 16'(xfer);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_hi_q <= '0;
            pt_q      <= 1'b0;
            code_q    <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_hi_q <= data_hi_d;
            pt_q      <= pt_d;
            code_q    <= code_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign code_out  = code_q;
    assign code_last = last_q;
    assign cw_count  = cnt_q;

endmodule

// File: tb/tb_hamming_code_encoder_tx.sv
// Directed self-checking bench for hamming_code_encoder_tx.
module tb_hamming_code_encoder_tx;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        parity_type;
    logic [7:1]  code_out;
    logic        m_valid;
    logic        m_ready;
    logic        code_last;
    logic [15:0] cw_count;
    logic [2:0]  inj_pos;

    int n_checks = 0;
    int n_fail   = 0;

    hamming_code_encoder_tx dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .parity_type (parity_type),
        .code_out    (code_out),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .code_last   (code_last),
        .cw_count    (cw_count),
        .inj_pos     (inj_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Presents a sample at a negedge, lets one posedge accept it, then scrambles
    // the inputs so any leakage into in-flight codewords shows up.
    task automatic send_sample(input logic [7:0] d, input logic pt, input logic [2:0] ip);
        @(negedge clk);
        s_data      = d;
        parity_type = pt;
        inj_pos     = ip;
        s_valid     = 1'b1;
        check("s_ready_at_accept", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid     = 1'b0;
        s_data      = ~d;
        parity_type = ~pt;
        inj_pos     = 3'd7;
    endtask

    // Waits (bounded) for the next negedge with m_valid high and checks the codeword.
    task automatic expect_cw(input string tag, input logic [7:1] exp_code, input logic exp_last);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!m_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_code"}, 32'(code_out), 32'(exp_code));
        check({tag, "_last"}, 32'(code_last), 32'(exp_last));
    endtask

    initial begin
        logic [7:1] inj_lo_exp;
        logic [7:1] inj_hi_exp;

        rst         = 1'b1;
        s_data      = 8'h00;
        s_valid     = 1'b0;
        parity_type = 1'b0;
        m_ready     = 1'b1;
        inj_pos     = 3'd0;
        #1;
        check("rst_s_ready",   32'(s_ready),   32'd1);
        check("rst_m_valid",   32'(m_valid),   32'd0);
        check("rst_code_out",  32'(code_out),  32'd0);
        check("rst_code_last", 32'(code_last), 32'd0);
        check("rst_cw_count",  32'(cw_count),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Even parity 0x0B
        send_sample(8'h0B, 1'b0, 3'd0);
        expect_cw("even0B_lo", 7'b1010101, 1'b0);
        expect_cw("even0B_hi", 7'b0000000, 1'b1);
        @(negedge clk);
        check("even0B_idle_valid", 32'(m_valid),   32'd0);
        check("even0B_idle_code",  32'(code_out),  32'(7'b0000000));
        check("even0B_idle_last",  32'(code_last), 32'd1);
        check("even0B_count",      32'(cw_count),  32'd2);

        // Odd parity 0xF0
        send_sample(8'hF0, 1'b1, 3'd0);
        expect_cw("oddF0_lo", 7'b0001011, 1'b0);
        expect_cw("oddF0_hi", 7'b1110100, 1'b1);
        @(negedge clk);
        check("oddF0_count", 32'(cw_count), 32'd4);

        // Back-pressure: even 0xFF with m_ready low for 5 cycles
        m_ready = 1'b0;
        send_sample(8'hFF, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid",   32'(m_valid),   32'd1);
            check("stall_code",    32'(code_out),  32'(7'b1111111));
            check("stall_last",    32'(code_last), 32'd0);
            check("stall_s_ready", 32'(s_ready),   32'd0);
        end
        check("stall_count", 32'(cw_count), 32'd4);
        m_ready = 1'b1;
        expect_cw("stallFF_hi", 7'b1111111, 1'b1);
        check("stallFF_hi_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("stallFF_count", 32'(cw_count), 32'd6);

        // Error injection at position 5 (only active when the macro is defined)
`ifdef HAMMING_ERR_INJECT_EN
        inj_lo_exp = 7'b1000101;
        inj_hi_exp = 7'b0010000;
`else
        inj_lo_exp = 7'b1010101;
        inj_hi_exp = 7'b0000000;
`endif
        send_sample(8'h0B, 1'b0, 3'd5);
        expect_cw("inj_lo", inj_lo_exp, 1'b0);
        expect_cw("inj_hi", inj_hi_exp, 1'b1);
        @(negedge clk);
        check("inj_count", 32'(cw_count), 32'd8);

        // Reset while in SEND_HI
        send_sample(8'h3C, 1'b0, 3'd0);
        expect_cw("rst3C_lo", 7'b1100001, 1'b0);
        expect_cw("rst3C_hi", 7'b0011110, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_m_valid",  32'(m_valid),  32'd0);
        check("midrst_cw_count", 32'(cw_count), 32'd0);
        check("midrst_s_ready",  32'(s_ready),  32'd1);
        check("midrst_code_out", 32'(code_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_m_valid", 32'(m_valid), 32'd0);
        end

        // Counter wrap: preload just below the top, then two transfers
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        send_sample(8'h00, 1'b0, 3'd0);
        expect_cw("wrap_lo", 7'b0000000, 1'b0);
        expect_cw("wrap_hi", 7'b0000000, 1'b1);
        check("wrap_count_ffff", 32'(cw_count), 32'h0000FFFF);
        @(negedge clk);
        check("wrap_count_zero", 32'(cw_count), 32'h00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_code_encoder_tx.md
HAMMING_CODE_ENCODER_TX -- requirements
Module: hamming_code_encoder_tx

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset. Ports: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-high reset).
REQ-002 s_data  input  8  ADC sample word to encode.
REQ-003 s_valid  input  1  s_data valid. s_ready  output  1  block can accept a sample.
REQ-004 parity_type  input  1  0 = even parity, 1 = odd parity; sampled at sample accept.
REQ-005 code_out  output  7 ([7:1])  Hamming(7,4) codeword; positions 1, 2 and 4 are parity, positions 3, 5, 6 and 7 are data.
REQ-006 m_valid  output  1  code_out valid. m_ready  input  1  downstream accepts the codeword.
REQ-007 code_last  output  1  high while code_out carries the high-nibble codeword.
REQ-008 cw_count  output  16  count of codewords transferred.
REQ-009 inj_pos  input  3  error-injection bit position (see Configuration).

Function
REQ-010 Data nibble mapping SHALL be: nibble bit0→code[3], bit1→code[5], bit2→code[6], bit3→code[7].
REQ-011 Parity bits SHALL be computed as follows, where pt is the latched parity_type:
- code[1] = code[3]^code[5]^code[7]^pt
- code[2] = code[3]^code[6]^code[7]^pt
- code[4] = code[5]^code[6]^code[7]^pt
REQ-012 The FSM SHALL have three states: IDLE, SEND_LO and SEND_HI.
REQ-013 s_ready SHALL be 1 only in IDLE.
REQ-014 A sample SHALL be accepted when s_valid and s_ready are both 1. On accept, s_data and parity_type SHALL be latched and the FSM SHALL go to SEND_LO.
REQ-015 In SEND_LO: m_valid=1, code_out = encoding of s_data[3:0], code_last=0. On m_ready the FSM SHALL go to SEND_HI.
REQ-016 In SEND_HI: m_valid=1, code_out = encoding of s_data[7:4], code_last=1. On m_ready the FSM SHALL go to IDLE.
REQ-017 Latency SHALL be 1 cycle: the low-nibble codeword is valid in the cycle after accept.
REQ-018 Maximum throughput SHALL be one sample per 3 cycles.
REQ-019 While m_valid=1 and m_ready=0, code_out, code_last and m_valid SHALL hold stable.
REQ-020 Changes on s_data and parity_type after accept SHALL NOT affect in-flight codewords.
REQ-021 code_out SHALL be driven from registers, not combinationally from the inputs.
REQ-022 cw_count SHALL increment by 1 on each cycle with m_valid and m_ready both 1. It SHALL wrap from 16'hFFFF to 16'h0000 without saturating.
REQ-023 In IDLE, m_valid SHALL be 0, and code_out and code_last SHALL hold their last values.

Reset
REQ-024 On rst=1, asynchronously and regardless of state:
- FSM → IDLE
- s_ready=1 (as a consequence of IDLE)
- m_valid=0, code_out=7'b0000000, code_last=0, cw_count=16'h0000
- latched sample and parity cleared
REQ-025 Reset asserted mid-transfer SHALL discard the in-flight sample. No codeword SHALL be emitted after release until a new accept.

Configuration
REQ-026 The error-injection feature SHALL be controlled by the macro HAMMING_ERR_INJECT_EN.
- Defined: when inj_pos≠0, bit code_out[inj_pos] SHALL be inverted on every emitted codeword. inj_pos SHALL be sampled at sample accept. inj_pos=0 SHALL mean no injection.
- Undefined: inj_pos SHALL be ignored, and code_out SHALL always be the clean codeword.

Verification
REQ-027 Even parity, s_data=8'h0B, m_ready=1 → code_out 7'b1010101 (code_last=0), then 7'b0000000 (code_last=1); cw_count=2.
REQ-028 Odd parity, s_data=8'hF0 → 7'b0001011, then 7'b1110100.
REQ-029 Even parity, s_data=8'hFF, m_ready held 0 for 5 cycles → code_out stable at 7'b1111111 with m_valid=1. When m_ready goes high, the second codeword is also 7'b1111111. s_ready stays 0 throughout.
REQ-030 rst pulsed while in SEND_HI → m_valid=0 and cw_count=0 immediately, and s_ready=1.
REQ-031 HAMMING_ERR_INJECT_EN defined, inj_pos=3'd5, even parity, s_data=8'h0B → low codeword 7'b1000101. Without the macro → 7'b1010101.
REQ-032 Preload cw_count to 16'hFFFF (65535 transfers), then one transfer → cw_count=16'h0000.
